fifo_burst_drain: RTL and testbench

Read-side consumer for the synchronous FIFO. Pops words from the FIFO read port (valid/ready, first-word fall-through), groups them into fixed-length bursts with start/end markers, and presents them on a downstream valid/ready stream through a 2-entry output buffer. Bursts are launched from the FIFO almost-empty flag; an optional timeout flushes residual words that never reach a full burst.

---
 rtl/fifo_burst_drain.sv | 171 +++++++++++++++++
 tb/tb_fifo_burst_drain.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_drain.sv
// Burst-forming read-side consumer for the synchronous FIFO.
// Optional residual-word flush on idle timeout: define BURST_TIMEOUT_EN.
module fifo_burst_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_fifo_valid,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_almostempty,
  output logic                  o_fifo_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sop,
  output logic                  o_eop,
  input  logic                  i_ready,
  output logic                  o_busy
);

  localparam int CW = $clog2(BURST_LEN) + 1;

  if (BURST_LEN < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("fifo_burst_drain: BURST_LEN must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;

  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]      buf_sop;
  logic [1:0]      buf_eop;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      occ;

  logic            pop;
  logic            xfer;
  logic            allow;
  logic            last_beat;
  logic            tag_sop;
  logic            tag_eop;

  assign last_beat = (beat_q == CW'(BURST_LEN - 1));
  assign allow     = (state_q == FLUSH) | (beat_q < CW'(BURST_LEN));

  // Pop request depends only on registered state and occupancy.
  assign o_fifo_ready = (state_q != IDLE) & (occ < 2'd2) & allow;

  assign pop  = o_fifo_ready & i_fifo_valid;
  assign xfer = o_valid & i_ready;

  assign tag_sop = (state_q == FLUSH) | (beat_q == '0);
  assign tag_eop = (state_q == FLUSH) | last_beat;

  assign o_valid = (occ != 2'd0);
  assign o_data  = buf_data[rd_ptr];
  assign o_sop   = buf_sop[rd_ptr];
  assign o_eop   = buf_eop[rd_ptr];
  assign o_busy  = (state_q != IDLE) | (occ != 2'd0);

`ifdef BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt_q;
  logic          timeout_hit;

  assign timeout_hit = i_fifo_valid & (tcnt_q == TW'(TIMEOUT - 1));

  // Idle timer: counts cycles of residual data sitting below threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q <= '0;
    end else if (pop || !i_fifo_valid ||
                 state_q != IDLE || state_d != IDLE) begin
      tcnt_q <= '0;
    end else if (tcnt_q != TW'(TIMEOUT)) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end
`else
  logic timeout_hit;

  assign timeout_hit = 1'b0;
`endif

  // State and beat counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Burst launch, back-to-back continuation and flush exit.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (!i_fifo_almostempty) begin
          state_d = BURST;
          beat_d  = '0;
        end else if (timeout_hit) begin
          state_d = FLUSH;
        end
      end
      BURST: begin
        if (pop) begin
          if (last_beat) begin
            beat_d = '0;
            if (i_fifo_almostempty) begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (!i_fifo_valid || !i_fifo_almostempty) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Two-entry output buffer, written on pop, read on transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
      end
      buf_sop <= '0;
      buf_eop <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= 2'd0;
    end else begin
      if (pop) begin
        buf_data[wr_ptr] <= i_fifo_data;
        buf_sop[wr_ptr]  <= tag_sop;
        buf_eop[wr_ptr]  <= tag_eop;
        wr_ptr           <= ~wr_ptr;
      end
      if (xfer) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({pop, xfer})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Scoreboard bench for fifo_burst_drain with a behavioural FIFO.
// Exercises the BURST_TIMEOUT_EN build when that macro is defined.
module tb_fifo_burst_drain;

  localparam int DW = 8;
  localparam int BL = 8;
  localparam int TO = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic          i_fifo_valid;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_almostempty;
  logic          o_fifo_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_sop;
  logic          o_eop;
  logic          i_ready;
  logic          o_busy;

  logic [DW-1:0] fifo_q [$];
  exp_t          exp_q [$];
  int            xcyc_q [$];

  int   n_cmp;
  int   n_bad;
  int   n_pop;
  int   n_xfer;
  int   cyc;
  logic pop_pending;
  logic saw_full;
  logic hold_v;
  logic [DW-1:0] hold_d;
  logic hold_s;
  logic hold_e;

  fifo_burst_drain #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_fifo_valid      (i_fifo_valid),
    .i_fifo_data       (i_fifo_data),
    .i_fifo_almostempty(i_fifo_almostempty),
    .o_fifo_ready      (o_fifo_ready),
    .o_valid           (o_valid),
    .o_data            (o_data),
    .o_sop             (o_sop),
    .o_eop             (o_eop),
    .i_ready           (i_ready),
    .o_busy            (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void refresh();
    i_fifo_valid       = (fifo_q.size() != 0);
    i_fifo_data        = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    i_fifo_almostempty = (fifo_q.size() <= BL - 1);
  endfunction

  task automatic load_burst(input int base, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      fifo_q.push_back(DW'(base + k));
      e.d = DW'(base + k);
      e.s = (k % BL == 0);
      e.e = (k % BL == BL - 1);
      exp_q.push_back(e);
    end
    refresh();
  endtask

  task automatic load_flush(input int base, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      fifo_q.push_back(DW'(base + k));
      e.d = DW'(base + k);
      e.s = 1'b1;
      e.e = 1'b1;
      exp_q.push_back(e);
    end
    refresh();
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    for (int i = 0; i < maxc && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  // FIFO model: apply the pop decided in the previous low phase.
  initial begin
    pop_pending = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        refresh();
      end
    end
  end

  // Monitor: scoreboard compare, stall stability, full-buffer backpressure.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset_n) begin
      n_pop       = 0;
      n_xfer      = 0;
      pop_pending = 1'b0;
      hold_v      = 1'b0;
    end else begin
      if (n_pop - n_xfer == 2) begin
        saw_full = 1'b1;
        chk("ready_when_full", 32'(o_fifo_ready), 0);
      end
      if (hold_v) begin
        chk("stall_valid", 32'(o_valid), 1);
        chk("stall_data", 32'(o_data), 32'(hold_d));
        chk("stall_tags", {30'd0, o_sop, o_eop}, {30'd0, hold_s, hold_e});
      end
      pop_pending = o_fifo_ready && i_fifo_valid;
      if (pop_pending) n_pop++;
      if (o_valid && i_ready) begin
        n_xfer++;
        xcyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(o_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(o_data), 32'(e.d));
          chk("beat_sop", 32'(o_sop), 32'(e.s));
          chk("beat_eop", 32'(o_eop), 32'(e.e));
        end
      end
      hold_v = o_valid && !i_ready;
      hold_d = o_data;
      hold_s = o_sop;
      hold_e = o_eop;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [3:0] pat;
    logic any_v;
    logic any_r;
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    saw_full = 1'b0;
    i_ready  = 1'b1;
    reset_n  = 1'b1;
    refresh();
    #3 reset_n = 1'b0;
    #2;
    chk("rst_ready", 32'(o_fifo_ready), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_sop", 32'(o_sop), 0);
    chk("rst_eop", 32'(o_eop), 0);
    chk("rst_busy", 32'(o_busy), 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Single burst, flag-to-valid latency, no bubbles, busy drop.
    repeat (2) @(posedge clk);
    #2;
    xcyc_q.delete();
    load_burst(8'h10, 8);
    @(negedge clk);
    chk("lat_ready0", 32'(o_fifo_ready), 0);
    @(negedge clk);
    chk("lat_ready1", 32'(o_fifo_ready), 1);
    chk("lat_valid0", 32'(o_valid), 0);
    @(negedge clk);
    chk("lat_valid1", 32'(o_valid), 1);
    chk("lat_data", 32'(o_data), 32'h10);
    wait_drain("t1_drain", 100);
    repeat (2) @(negedge clk);
    chk("t1_busy", 32'(o_busy), 0);
    chk("t1_count", 32'(xcyc_q.size()), 8);
    if (xcyc_q.size() == 8)
      chk("t1_gap", 32'(xcyc_q[7] - xcyc_q[0]), 7);

    // Two back-to-back bursts.
    @(posedge clk);
    #2;
    xcyc_q.delete();
    load_burst(8'h20, 16);
    wait_drain("t2_drain", 100);
    repeat (2) @(negedge clk);
    chk("t2_busy", 32'(o_busy), 0);
    chk("t2_count", 32'(xcyc_q.size()), 16);
    if (xcyc_q.size() == 16)
      chk("t2_gap", 32'(xcyc_q[15] - xcyc_q[0]), 15);

    // Downstream backpressure with pattern 1,0,0,1.
    @(posedge clk);
    #2;
    saw_full = 1'b0;
    pat = 4'b1001;
    load_burst(8'h30, 8);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1 i_ready = pat[c % 4];
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    wait_drain("t3_drain", 50);
    chk("t3_saw_full", 32'(saw_full), 1);
    repeat (2) @(negedge clk);
    chk("t3_busy", 32'(o_busy), 0);

    // Reset in the middle of a burst.
    @(posedge clk);
    #2;
    load_burst(8'h50, 8);
    base = n_xfer;
    for (int i = 0; i < 50 && n_xfer - base < 4; i++) begin
      @(negedge clk);
    end
    chk("t4_beats_before", 32'(n_xfer - base), 4);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    refresh();
    #1;
    chk("t4_ready", 32'(o_fifo_ready), 0);
    chk("t4_valid", 32'(o_valid), 0);
    chk("t4_data", 32'(o_data), 0);
    chk("t4_sop", 32'(o_sop), 0);
    chk("t4_eop", 32'(o_eop), 0);
    chk("t4_busy", 32'(o_busy), 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #2;
    load_burst(8'h40, 8);
    wait_drain("t4_drain", 100);
    repeat (2) @(negedge clk);
    chk("t4_busy_end", 32'(o_busy), 0);

    // Residual words below the burst threshold.
    @(posedge clk);
    #2;
    any_v = 1'b0;
    any_r = 1'b0;
`ifdef BURST_TIMEOUT_EN
    load_flush(8'h60, 3);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      any_v = any_v | o_valid;
    end
    chk("t5_quiet", 32'(any_v), 0);
    wait_drain("t5_drain", 100);
    repeat (2) @(negedge clk);
    chk("t5_busy", 32'(o_busy), 0);
    chk("t5_fifo_empty", 32'(fifo_q.size()), 0);
`else
    for (int k = 0; k < 3; k++) fifo_q.push_back(DW'(8'h60 + k));
    refresh();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      any_v = any_v | o_valid;
      any_r = any_r | o_fifo_ready;
    end
    chk("t5_no_valid", 32'(any_v), 0);
    chk("t5_no_ready", 32'(any_r), 0);
    chk("t5_fifo_kept", 32'(fifo_q.size()), 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
